exception_ctrl: RTL and testbench
=================================

// Module: exception_ctrl
// PURPOSE
//  Commit-stage exception/interrupt arbiter directly upstream of COP0. Prioritises per-instruction
//  exception flags, pending interrupts and ERET. Drives COP0's exp_* update bus, pipeline flush and
//  a fetch redirect (exception vector or EPC). Also synchronises raw HW interrupt lines into COP0 hint.
// PARAMETERS
//  RESET_PC     32'hBFC0_0000  redirect_pc value out of reset
//  SYNC_STAGES  2              flops per hw_int bit (only with INT_SYNC_EN)
// PORTS
//  clk               in   1   clock
//  rst_n             in   1   asynchronous active-low reset
//  hw_int            in   5   raw HW interrupt lines
//  cp0_hint          out  5   hw_int (synchronised) -> COP0 hint
//  commit_valid      in   1   instruction presented at commit
//  commit_ready      out  1   commit handshake; low while not IDLE
//  commit_pc         in   32  PC of committing instruction
//  commit_bd         in   1   instruction sits in a delay slot
//  commit_exc        in   10  exception flags, bit order per package (EXC_*)
//  commit_eret       in   1   instruction is ERET
//  commit_fetch_va   in   32  faulting fetch address
//  commit_data_va    in   32  faulting load/store address
//  commit_asid       in   8   ASID of faulting access
//  cp0_entryhi       in   32  current EntryHi
//  allow_interrupt   in   1   from COP0 (Status IE/EXL/ERL)
//  interrupt_flag    in   8   from COP0 (IM & IP)
//  exl_set           in   1   Status.EXL
//  use_special_iv    in   1   Cause.IV
//  use_bootstrap_iv  in   1   Status.BEV
//  ebase_address     in   32  EBase
//  epc_address       in   32  EPC
//  exp_en, exp_badvaddr_en, exp_bd, exl_clean, exp_asid_en  out 1 each   COP0 update strobes
//  exp_code          out  5   ExcCode
//  exp_epc, exp_badvaddr      out 32 each
//  exp_asid          out  8
//  flush             out  1   one-cycle pipeline kill
//  redirect_valid    out  1   redirect request to fetch
//  redirect_ready    in   1   fetch accepts redirect
//  redirect_pc       out  32  redirect target
// BEHAVIOUR
//  - Reset: all outputs 0 except commit_ready=1 and redirect_pc=RESET_PC; state IDLE; sync flops 0.
//  - FSM IDLE/REDIRECT. Event at cycle T = commit_valid & commit_ready & (irq | |commit_exc | commit_eret),
//    where irq = allow_interrupt & |interrupt_flag & ~exl_set.
//  - T+1: exp_en=1 and flush=1 for exactly one cycle; redirect_valid=1; state REDIRECT; commit_ready=0.
//  - REDIRECT: redirect_valid/redirect_pc held stable until redirect_ready; IDLE the cycle after the handshake.
//  - All COP0 inputs are sampled at T and registered; outputs do not track later COP0 changes.
//  - Priority: Int(0) > AdEL-fetch(4) > TLBL-fetch(2) > RI(10) > Sys(8) > Bp(9) > Ov(12) > AdEL/AdES-data(4/5)
//    > TLBL/TLBS-data(2/3) > Mod(1) > ERET. Any exception with ERET set wins over the ERET.
//  - Exception: exp_epc = commit_bd ? commit_pc-4 : commit_pc (mod 2^32); exp_bd=commit_bd; exl_clean=0.
//  - Exception vector: base = use_bootstrap_iv ? 32'hBFC0_0200 : ebase_address.
//    Offset 0x000 for a TLB refill with exl_set=0; 0x200 for Int with use_special_iv=1; else 0x180.
//  - Address/TLB codes: exp_badvaddr_en=1, exp_badvaddr = fetch or data VA. TLB codes also set exp_asid_en=1 and
//    exp_asid=commit_asid. Other codes: exp_badvaddr=cp0_entryhi so Context/EntryHi VPN2 are preserved.
//  - ERET: exp_en=1, exl_clean=1, exp_code=0, exp_epc=epc_address, exp_bd=0, exp_badvaddr=cp0_entryhi;
//    redirect_pc=epc_address.
//  - rst_n asserted mid-REDIRECT: immediate return to reset values; the pending redirect is dropped.
// CONFIGURATION
//  INT_SYNC_EN defined: each hw_int bit passes a SYNC_STAGES-deep flop chain to cp0_hint (latency SYNC_STAGES).
//  INT_SYNC_EN undefined: cp0_hint = hw_int combinationally; SYNC_STAGES unused.
// STRUCTURE
//  Package sirius_exc_pkg: excode_t enum (INT,MOD,TLBL,TLBS,ADEL,ADES,SYS,BP,RI,OV), EXC_* bit indices of
//  commit_exc, VEC_REFILL/VEC_GENERAL/VEC_IRQ offsets, BEV_BASE. Sub-module int_sync: parameterised synchroniser.
// TESTING
//  1 Sys at pc=0x8000_1000, bd=0, BEV=0, EBase=0x8000_0000 -> T+1 exp_en, code 8, epc 0x8000_1000, pc 0x8000_0180.
//  2 Ov in slot pc=0x8000_2004, bd=1 -> exp_epc 0x8000_2000, exp_bd=1, code 12.
//  3 TLBL data va=0x0040_0000, EXL=0, asid 0x12 -> offset 0x000, badvaddr/asid enables set, exp_asid=0x12.
//  4 irq with IV=1 and RI on same entry -> code 0, redirect 0x8000_0200; redirect_ready held low 3 cycles -> pc stable, ready=0.
//  5 ERET, EPC=0x8000_3000 -> exl_clean=1, redirect 0x8000_3000; ERET+AdEL-fetch -> code 4 wins.
//  6 rst_n low in REDIRECT -> redirect_valid=0, commit_ready=1 asynchronously.
//    With INT_SYNC_EN: hw_int[2] rises -> cp0_hint[2] after 2 clocks.

Source files
------------

// File: rtl/sirius_exc_pkg.sv
// Shared exception codes, commit_exc bit layout and vector constants for the commit-stage exception controller.
// Mod is flagged by EXC_TLBL_D and EXC_TLBS_D together, because commit_exc has only ten bits.
package sirius_exc_pkg;

  typedef enum logic [4:0] {
    EC_INT  = 5'd0,
    EC_MOD  = 5'd1,
    EC_TLBL = 5'd2,
    EC_TLBS = 5'd3,
    EC_ADEL = 5'd4,
    EC_ADES = 5'd5,
    EC_SYS  = 5'd8,
    EC_BP   = 5'd9,
    EC_RI   = 5'd10,
    EC_OV   = 5'd12
  } excode_t;

  // commit_exc bit positions; the fetch-side and data-side sources are kept apart
  // so that BadVAddr can be taken from the matching address.
  localparam int EXC_WIDTH   = 10;
  localparam int EXC_ADEL_IF = 0;
  localparam int EXC_TLBL_IF = 1;
  localparam int EXC_RI      = 2;
  localparam int EXC_SYS     = 3;
  localparam int EXC_BP      = 4;
  localparam int EXC_OV      = 5;
  localparam int EXC_ADEL_D  = 6;
  localparam int EXC_ADES_D  = 7;
  localparam int EXC_TLBL_D  = 8;
  localparam int EXC_TLBS_D  = 9;

  localparam logic [31:0] VEC_REFILL  = 32'h0000_0000;
  localparam logic [31:0] VEC_GENERAL = 32'h0000_0180;
  localparam logic [31:0] VEC_IRQ     = 32'h0000_0200;
  localparam logic [31:0] BEV_BASE    = 32'hBFC0_0200;

  typedef enum logic {
    ST_IDLE,
    ST_REDIRECT
  } state_t;

  function automatic logic [31:0] vector_base(input logic bev, input logic [31:0] ebase);
    return bev ? BEV_BASE : ebase;
  endfunction

endpackage

// File: rtl/exception_ctrl_int_sync.sv
// Per-bit flop-chain synchroniser for the raw hardware interrupt lines.
// STAGES of zero collapses the chain to a straight wire.
module int_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (STAGES == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;
    assign q_o = d_i;
  end else begin : g_chain
    logic [WIDTH-1:0] chain_q [STAGES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < STAGES; i++) chain_q[i] <= '0;
      end else begin
        chain_q[0] <= d_i;
        for (int i = 1; i < STAGES; i++) chain_q[i] <= chain_q[i-1];
      end
    end

    assign q_o = chain_q[STAGES-1];
  end

endmodule

// File: rtl/exception_ctrl.sv
// Commit-stage exception/interrupt/ERET arbiter feeding COP0 and the fetch redirect.
// Define INT_SYNC_EN to pass hw_int through a SYNC_STAGES-deep synchroniser before cp0_hint.
module exception_ctrl
  import sirius_exc_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'hBFC0_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [4:0]           hw_int_i,
  output logic [4:0]           cp0_hint_o,
  input  logic                 commit_valid_i,
  output logic                 commit_ready_o,
  input  logic [31:0]          commit_pc_i,
  input  logic                 commit_bd_i,
  input  logic [EXC_WIDTH-1:0] commit_exc_i,
  input  logic                 commit_eret_i,
  input  logic [31:0]          commit_fetch_va_i,
  input  logic [31:0]          commit_data_va_i,
  input  logic [7:0]           commit_asid_i,
  input  logic [31:0]          cp0_entryhi_i,
  input  logic                 allow_interrupt_i,
  input  logic [7:0]           interrupt_flag_i,
  input  logic                 exl_set_i,
  input  logic                 use_special_iv_i,
  input  logic                 use_bootstrap_iv_i,
  input  logic [31:0]          ebase_address_i,
  input  logic [31:0]          epc_address_i,
  output logic                 exp_en_o,
  output logic                 exp_badvaddr_en_o,
  output logic                 exp_bd_o,
  output logic                 exl_clean_o,
  output logic                 exp_asid_en_o,
  output logic [4:0]           exp_code_o,
  output logic [31:0]          exp_epc_o,
  output logic [31:0]          exp_badvaddr_o,
  output logic [7:0]           exp_asid_o,
  output logic                 flush_o,
  output logic                 redirect_valid_o,
  input  logic                 redirect_ready_i,
  output logic [31:0]          redirect_pc_o
);

`ifdef INT_SYNC_EN
  localparam int HINT_STAGES = SYNC_STAGES;
`else
  localparam int HINT_STAGES = 0;
  logic unused_sync_stages;
  assign unused_sync_stages = ^SYNC_STAGES;
`endif

  int_sync #(
    .WIDTH  (5),
    .STAGES (HINT_STAGES)
  ) u_int_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (hw_int_i),
    .q_o    (cp0_hint_o)
  );

  state_t      state_q;
  logic        commit_ready_q;
  logic        exp_en_q, exp_badvaddr_en_q, exp_bd_q, exl_clean_q, exp_asid_en_q;
  excode_t     exp_code_q;
  logic [31:0] exp_epc_q, exp_badvaddr_q;
  logic [7:0]  exp_asid_q;
  logic        flush_q, redirect_valid_q;
  logic [31:0] redirect_pc_q;

  logic        irq;
  logic        take_event;
  excode_t     dec_code;
  logic        dec_badvaddr_en;
  logic        dec_asid_en;
  logic        dec_refill;
  logic        dec_eret;
  logic [31:0] dec_badvaddr;
  logic [31:0] dec_epc;
  logic [31:0] dec_vector;
  logic [1:0]  data_tlb;

  assign irq        = allow_interrupt_i & (|interrupt_flag_i) & ~exl_set_i;
  assign take_event = commit_valid_i & commit_ready_q & (irq | (|commit_exc_i) | commit_eret_i);
  assign data_tlb   = {commit_exc_i[EXC_TLBS_D], commit_exc_i[EXC_TLBL_D]};
  assign dec_epc    = commit_bd_i ? (commit_pc_i - 32'd4) : commit_pc_i;

  // Priority walk; the final else is the ERET path, reached only with no exception.
  always_comb begin
    dec_code        = EC_INT;
    dec_badvaddr_en = 1'b0;
    dec_asid_en     = 1'b0;
    dec_refill      = 1'b0;
    dec_eret        = 1'b0;
    dec_badvaddr    = cp0_entryhi_i;
    if (irq) begin
      dec_code = EC_INT;
    end else if (commit_exc_i[EXC_ADEL_IF]) begin
      dec_code        = EC_ADEL;
      dec_badvaddr_en = 1'b1;
      dec_badvaddr    = commit_fetch_va_i;
    end else if (commit_exc_i[EXC_TLBL_IF]) begin
      dec_code        = EC_TLBL;
      dec_badvaddr_en = 1'b1;
      dec_asid_en     = 1'b1;
      dec_refill      = 1'b1;
      dec_badvaddr    = commit_fetch_va_i;
    end else if (commit_exc_i[EXC_RI]) begin
      dec_code = EC_RI;
    end else if (commit_exc_i[EXC_SYS]) begin
      dec_code = EC_SYS;
    end else if (commit_exc_i[EXC_BP]) begin
      dec_code = EC_BP;
    end else if (commit_exc_i[EXC_OV]) begin
      dec_code = EC_OV;
    end else if (commit_exc_i[EXC_ADEL_D]) begin
      dec_code        = EC_ADEL;
      dec_badvaddr_en = 1'b1;
      dec_badvaddr    = commit_data_va_i;
    end else if (commit_exc_i[EXC_ADES_D]) begin
      dec_code        = EC_ADES;
      dec_badvaddr_en = 1'b1;
      dec_badvaddr    = commit_data_va_i;
    end else if (data_tlb != 2'b00) begin
      dec_badvaddr_en = 1'b1;
      dec_asid_en     = 1'b1;
      dec_badvaddr    = commit_data_va_i;
      case (data_tlb)
        2'b01:   begin dec_code = EC_TLBL; dec_refill = 1'b1; end
        2'b10:   begin dec_code = EC_TLBS; dec_refill = 1'b1; end
        default: dec_code = EC_MOD;
      endcase
    end else begin
      dec_eret = 1'b1;
    end
  end

  always_comb begin
    dec_vector = vector_base(use_bootstrap_iv_i, ebase_address_i);
    if (dec_refill && !exl_set_i) begin
      dec_vector = dec_vector + VEC_REFILL;
    end else if (irq && use_special_iv_i) begin
      dec_vector = dec_vector + VEC_IRQ;
    end else begin
      dec_vector = dec_vector + VEC_GENERAL;
    end
  end

  // COP0 strobes and flush pulse for one cycle; the data fields and redirect target hold until the next event.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q           <= ST_IDLE;
      commit_ready_q    <= 1'b1;
      exp_en_q          <= 1'b0;
      exp_badvaddr_en_q <= 1'b0;
      exp_bd_q          <= 1'b0;
      exl_clean_q       <= 1'b0;
      exp_asid_en_q     <= 1'b0;
      exp_code_q        <= EC_INT;
      exp_epc_q         <= '0;
      exp_badvaddr_q    <= '0;
      exp_asid_q        <= '0;
      flush_q           <= 1'b0;
      redirect_valid_q  <= 1'b0;
      redirect_pc_q     <= RESET_PC;
    end else begin
      exp_en_q          <= 1'b0;
      exp_badvaddr_en_q <= 1'b0;
      exp_bd_q          <= 1'b0;
      exl_clean_q       <= 1'b0;
      exp_asid_en_q     <= 1'b0;
      flush_q           <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (take_event) begin
            state_q           <= ST_REDIRECT;
            commit_ready_q    <= 1'b0;
            redirect_valid_q  <= 1'b1;
            exp_en_q          <= 1'b1;
            flush_q           <= 1'b1;
            exp_code_q        <= dec_code;
            exp_badvaddr_q    <= dec_badvaddr;
            exp_badvaddr_en_q <= dec_badvaddr_en;
            exp_asid_en_q     <= dec_asid_en;
            exp_asid_q        <= dec_asid_en ? commit_asid_i : 8'h00;
            exl_clean_q       <= dec_eret;
            exp_bd_q          <= dec_eret ? 1'b0 : commit_bd_i;
            exp_epc_q         <= dec_eret ? epc_address_i : dec_epc;
            redirect_pc_q     <= dec_eret ? epc_address_i : dec_vector;
          end
        end
        ST_REDIRECT: begin
          if (redirect_ready_i) begin
            state_q          <= ST_IDLE;
            commit_ready_q   <= 1'b1;
            redirect_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q          <= ST_IDLE;
          commit_ready_q   <= 1'b1;
          redirect_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign commit_ready_o    = commit_ready_q;
  assign exp_en_o          = exp_en_q;
  assign exp_badvaddr_en_o = exp_badvaddr_en_q;
  assign exp_bd_o          = exp_bd_q;
  assign exl_clean_o       = exl_clean_q;
  assign exp_asid_en_o     = exp_asid_en_q;
  assign exp_code_o        = exp_code_q;
  assign exp_epc_o         = exp_epc_q;
  assign exp_badvaddr_o    = exp_badvaddr_q;
  assign exp_asid_o        = exp_asid_q;
  assign flush_o           = flush_q;
  assign redirect_valid_o  = redirect_valid_q;
  assign redirect_pc_o     = redirect_pc_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Self-checking bench for exception_ctrl: directed commit scenarios plus randomized commits against a priority-table model.
module tb_exception_ctrl;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  hw_int = '0;
  logic [4:0]  cp0_hint;
  logic        commit_valid = 1'b0;
  logic        commit_ready;
  logic [31:0] commit_pc = '0;
  logic        commit_bd = 1'b0;
  logic [9:0]  commit_exc = '0;
  logic        commit_eret = 1'b0;
  logic [31:0] commit_fetch_va = '0;
  logic [31:0] commit_data_va = '0;
  logic [7:0]  commit_asid = '0;
  logic [31:0] cp0_entryhi = '0;
  logic        allow_interrupt = 1'b0;
  logic [7:0]  interrupt_flag = '0;
  logic        exl_set = 1'b0;
  logic        use_special_iv = 1'b0;
  logic        use_bootstrap_iv = 1'b0;
  logic [31:0] ebase_address = '0;
  logic [31:0] epc_address = '0;
  logic        exp_en, exp_badvaddr_en, exp_bd, exl_clean, exp_asid_en;
  logic [4:0]  exp_code;
  logic [31:0] exp_epc, exp_badvaddr;
  logic [7:0]  exp_asid;
  logic        flush;
  logic        redirect_valid;
  logic        redirect_ready = 1'b0;
  logic [31:0] redirect_pc;

  int total = 0;
  int bad = 0;

  exception_ctrl #(.RESET_PC(RESET_PC), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .hw_int_i(hw_int), .cp0_hint_o(cp0_hint),
    .commit_valid_i(commit_valid), .commit_ready_o(commit_ready), .commit_pc_i(commit_pc),
    .commit_bd_i(commit_bd), .commit_exc_i(commit_exc), .commit_eret_i(commit_eret),
    .commit_fetch_va_i(commit_fetch_va), .commit_data_va_i(commit_data_va),
    .commit_asid_i(commit_asid), .cp0_entryhi_i(cp0_entryhi),
    .allow_interrupt_i(allow_interrupt), .interrupt_flag_i(interrupt_flag), .exl_set_i(exl_set),
    .use_special_iv_i(use_special_iv), .use_bootstrap_iv_i(use_bootstrap_iv),
    .ebase_address_i(ebase_address), .epc_address_i(epc_address),
    .exp_en_o(exp_en), .exp_badvaddr_en_o(exp_badvaddr_en), .exp_bd_o(exp_bd),
    .exl_clean_o(exl_clean), .exp_asid_en_o(exp_asid_en), .exp_code_o(exp_code),
    .exp_epc_o(exp_epc), .exp_badvaddr_o(exp_badvaddr), .exp_asid_o(exp_asid),
    .flush_o(flush), .redirect_valid_o(redirect_valid), .redirect_ready_i(redirect_ready),
    .redirect_pc_o(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        bd;
    logic [9:0]  exc;
    logic        eret;
    logic [31:0] fva, dva, entryhi, ebase, epc;
    logic [7:0]  asid, iflag;
    logic        allow, exl, iv, bev;
  } stim_t;

  typedef struct packed {
    logic        exp_en, bad_en, bd, exl_clean, asid_en;
    logic [4:0]  code;
    logic [31:0] epc, badva;
    logic [7:0]  asid;
    logic        flush, rv, ready;
    logic [31:0] rpc;
  } obs_t;

  function automatic obs_t sample();
    obs_t o;
    o.exp_en = exp_en; o.bad_en = exp_badvaddr_en; o.bd = exp_bd; o.exl_clean = exl_clean;
    o.asid_en = exp_asid_en; o.code = exp_code; o.epc = exp_epc; o.badva = exp_badvaddr;
    o.asid = exp_asid; o.flush = flush; o.rv = redirect_valid; o.ready = commit_ready;
    o.rpc = redirect_pc;
    return o;
  endfunction

  // Reference: walk the architectural priority list; data-side TLB bits read as 01=TLBL, 10=TLBS, 11=Mod.
  function automatic obs_t model(input stim_t s);
    obs_t e;
    int   codeOf[8]  = '{4, 2, 10, 8, 9, 12, 4, 5};
    int   vaSrc[8]   = '{1, 1, 0, 0, 0, 0, 2, 2};
    int   found = -1;
    int   code = 0;
    int   src = 0;
    bit   tlb = 0, refill = 0, isIrq, isEret = 0;
    logic [31:0] base, off;
    isIrq = s.allow && (s.iflag != 0) && !s.exl;
    if (!isIrq) begin
      for (int i = 0; i < 8; i++) if (found < 0 && s.exc[i]) found = i;
      if (found >= 0) begin
        code = codeOf[found]; src = vaSrc[found];
        if (found == 1) begin tlb = 1; refill = 1; end
      end else if (s.exc[9:8] != 0) begin
        src = 2; tlb = 1;
        code = (s.exc[9:8] == 2'b01) ? 2 : (s.exc[9:8] == 2'b10) ? 3 : 1;
        refill = (code != 1);
      end else begin
        isEret = 1;
      end
    end
    base = s.bev ? 32'hBFC0_0200 : s.ebase;
    off  = (refill && !s.exl) ? 32'h0 : (isIrq && s.iv) ? 32'h200 : 32'h180;
    e = '0;
    e.exp_en = 1; e.flush = 1; e.rv = 1; e.ready = 0;
    e.code = 5'(code);
    e.bad_en = (src != 0);
    e.badva = (src == 1) ? s.fva : (src == 2) ? s.dva : s.entryhi;
    e.asid_en = tlb;
    e.asid = tlb ? s.asid : 8'h00;
    if (isEret) begin
      e.exl_clean = 1; e.epc = s.epc; e.bd = 0; e.rpc = s.epc;
    end else begin
      e.bd = s.bd; e.epc = s.bd ? s.pc - 32'd4 : s.pc; e.rpc = base + off;
    end
    return e;
  endfunction

  function automatic stim_t quietStim();
    stim_t s;
    s.pc = 32'h8000_0000; s.bd = 0; s.exc = '0; s.eret = 0; s.fva = 32'h1111_1110;
    s.dva = 32'h2222_2220; s.entryhi = 32'h3333_3300; s.ebase = 32'h8000_0000;
    s.epc = 32'h8000_3000; s.asid = 8'h00; s.iflag = 8'h00; s.allow = 0; s.exl = 0;
    s.iv = 0; s.bev = 0;
    return s;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s.pc = {$urandom} & 32'hFFFF_FFFC; s.bd = 1'($urandom);
    for (int i = 0; i < 10; i++) s.exc[i] = ($urandom % 6) == 0;
    s.eret = ($urandom % 3) == 0; s.fva = $urandom; s.dva = $urandom; s.entryhi = $urandom;
    s.ebase = {$urandom} & 32'hFFFF_F000; s.epc = $urandom; s.asid = 8'($urandom);
    s.iflag = (($urandom % 4) == 0) ? 8'($urandom) : 8'h00;
    s.allow = 1'($urandom); s.exl = (($urandom % 4) == 0); s.iv = 1'($urandom);
    s.bev = (($urandom % 4) == 0);
    return s;
  endfunction

  task automatic drive(input stim_t s);
    commit_pc = s.pc; commit_bd = s.bd; commit_exc = s.exc; commit_eret = s.eret;
    commit_fetch_va = s.fva; commit_data_va = s.dva; commit_asid = s.asid;
    cp0_entryhi = s.entryhi; allow_interrupt = s.allow; interrupt_flag = s.iflag;
    exl_set = s.exl; use_special_iv = s.iv; use_bootstrap_iv = s.bev;
    ebase_address = s.ebase; epc_address = s.epc;
  endtask

  // Present one commit at edge T, then sample at the falling edge of T+1 with COP0 inputs scrambled.
  task automatic applyCommit(input stim_t s, output obs_t o);
    @(negedge clk);
    drive(s);
    commit_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drive(randStim());
    o = sample();
  endtask

  task automatic handshake();
    @(negedge clk);
    commit_valid = 1'b0;
    redirect_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    redirect_ready = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o, e;
    rst_n = 1'b0;
    #12;
    o = sample();
    e = '0; e.ready = 1; e.rpc = RESET_PC;
    total++;
    if (o !== e) begin
      bad++;
      $display("[TB] FAIL reset_state got=%h want=%h", o, e);
    end
    total++;
    if (cp0_hint !== 5'h0) begin
      bad++;
      $display("[TB] FAIL reset_hint got=%h want=0", cp0_hint);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    stim_t s;
    obs_t  o, e;
    // Sys, not in a delay slot
    s = quietStim(); s.pc = 32'h8000_1000; s.exc[3] = 1;
    applyCommit(s, o); e = model(s);
    total++;
    if (o !== e || o.rpc !== 32'h8000_0180 || o.code !== 5'd8) begin
      bad++; $display("[TB] FAIL sys got=%h want=%h", o, e);
    end
    handshake();
    // Ov in a delay slot
    s = quietStim(); s.pc = 32'h8000_2004; s.bd = 1; s.exc[5] = 1;
    applyCommit(s, o); e = model(s);
    total++;
    if (o !== e || o.epc !== 32'h8000_2000 || o.bd !== 1'b1 || o.code !== 5'd12) begin
      bad++; $display("[TB] FAIL ov_slot got=%h want=%h", o, e);
    end
    handshake();
    // TLBL data refill
    s = quietStim(); s.exc[8] = 1; s.dva = 32'h0040_0000; s.asid = 8'h12;
    applyCommit(s, o); e = model(s);
    total++;
    if (o !== e || o.rpc !== 32'h8000_0000 || o.asid !== 8'h12 || o.bad_en !== 1'b1) begin
      bad++; $display("[TB] FAIL tlbl_data got=%h want=%h", o, e);
    end
    handshake();
    // ERET alone
    s = quietStim(); s.eret = 1; s.epc = 32'h8000_3000;
    applyCommit(s, o); e = model(s);
    total++;
    if (o !== e || o.exl_clean !== 1'b1 || o.rpc !== 32'h8000_3000) begin
      bad++; $display("[TB] FAIL eret got=%h want=%h", o, e);
    end
    handshake();
    // ERET together with AdEL-fetch
    s = quietStim(); s.eret = 1; s.exc[0] = 1; s.fva = 32'h8000_0003;
    applyCommit(s, o); e = model(s);
    total++;
    if (o !== e || o.code !== 5'd4 || o.exl_clean !== 1'b0) begin
      bad++; $display("[TB] FAIL eret_adel got=%h want=%h", o, e);
    end
    handshake();
    // Mod: both data-TLB bits, general vector even with EXL clear
    s = quietStim(); s.exc[9:8] = 2'b11; s.bev = 1; s.asid = 8'h5A;
    applyCommit(s, o); e = model(s);
    total++;
    if (o !== e || o.code !== 5'd1 || o.rpc !== 32'hBFC0_0380) begin
      bad++; $display("[TB] FAIL mod got=%h want=%h", o, e);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    stim_t s;
    obs_t  o, e, h;
    s = quietStim(); s.allow = 1; s.iflag = 8'h04; s.iv = 1; s.exc[2] = 1;
    applyCommit(s, o); e = model(s);
    total++;
    if (o !== e || o.code !== 5'd0 || o.rpc !== 32'h8000_0200) begin
      bad++; $display("[TB] FAIL irq_iv got=%h want=%h", o, e);
    end
    commit_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(randStim());
      h = sample();
      total++;
      if (h.rv !== 1'b1 || h.ready !== 1'b0 || h.rpc !== e.rpc || h.exp_en !== 1'b0 || h.flush !== 1'b0) begin
        bad++; $display("[TB] FAIL hold_%0d got=%h want rpc=%h", c, h, e.rpc);
      end
    end
    handshake();
    h = sample();
    total++;
    if (h.rv !== 1'b0 || h.ready !== 1'b1 || h.exp_en !== 1'b0) begin
      bad++; $display("[TB] FAIL after_handshake rv=%b ready=%b exp_en=%b want 0/1/0", h.rv, h.ready, h.exp_en);
    end
  endtask

  task automatic test_random();
    stim_t s;
    obs_t  o, e;
    bit    fires;
    for (int n = 0; n < 60; n++) begin
      s = randStim();
      fires = (s.allow && s.iflag != 0 && !s.exl) || (s.exc != 0) || s.eret;
      applyCommit(s, o);
      total++;
      if (fires) begin
        e = model(s);
        if (o !== e) begin
          bad++; $display("[TB] FAIL rand_%0d got=%h want=%h", n, o, e);
        end
        handshake();
      end else begin
        if (o.exp_en !== 1'b0 || o.flush !== 1'b0 || o.rv !== 1'b0 || o.ready !== 1'b1) begin
          bad++; $display("[TB] FAIL rand_quiet_%0d en=%b fl=%b rv=%b rdy=%b want 0/0/0/1", n, o.exp_en, o.flush, o.rv, o.ready);
        end
        commit_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_redirect();
    stim_t s;
    obs_t  o;
    s = quietStim(); s.exc[4] = 1;
    applyCommit(s, o);
    commit_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (redirect_valid !== 1'b0 || commit_ready !== 1'b1 || redirect_pc !== RESET_PC || exp_en !== 1'b0) begin
      bad++; $display("[TB] FAIL async_reset rv=%b ready=%b pc=%h en=%b", redirect_valid, commit_ready, redirect_pc, exp_en);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (redirect_valid !== 1'b0 || commit_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL post_reset rv=%b ready=%b want 0/1", redirect_valid, commit_ready);
    end
  endtask

  task automatic test_hint();
    @(negedge clk);
    hw_int = 5'b00100;
`ifdef INT_SYNC_EN
    #1;
    total++;
    if (cp0_hint !== 5'h0) begin
      bad++; $display("[TB] FAIL hint_0clk got=%h want=00", cp0_hint);
    end
    @(negedge clk);
    total++;
    if (cp0_hint !== 5'h0) begin
      bad++; $display("[TB] FAIL hint_1clk got=%h want=00", cp0_hint);
    end
    @(negedge clk);
    total++;
    if (cp0_hint !== 5'b00100) begin
      bad++; $display("[TB] FAIL hint_2clk got=%h want=04", cp0_hint);
    end
`else
    #1;
    total++;
    if (cp0_hint !== 5'b00100) begin
      bad++; $display("[TB] FAIL hint_comb got=%h want=04", cp0_hint);
    end
`endif
    hw_int = 5'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_mid_redirect();
    test_hint();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
